reg_file_16bit: RTL



---
 rtl/reg_file_16bit.sv | 92 +++++++++
 1 files changed

// File: rtl/reg_file_16bit.sv
// reg_file_16bit: eight-entry register file with hardwired-zero R0, two
// combinational read ports, optional write-to-read bypass, and a Z/N/C flag
// register capturing the adder result flags.
module reg_file_16bit #(
   parameter int DEPTH  = 8,
   parameter int WIDTH  = 16,
   parameter bit BYPASS = 1'b0
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             WE,
   input  logic [2:0]       WA,
   input  logic [WIDTH-1:0] WD,
   input  logic [2:0]       RA1,
   input  logic [2:0]       RA2,
   output logic [WIDTH-1:0] RD1,
   output logic [WIDTH-1:0] RD2,
   input  logic             FWE,
   input  logic [WIDTH-1:0] Y_in,
   input  logic             Cout_in,
   output logic             Z,
   output logic             N,
   output logic             C
);

   // R0 has no storage; only R1..R(DEPTH-1) are real flops.
   logic [WIDTH-1:0] regs_q [1:DEPTH-1];
   logic [WIDTH-1:0] regs_d [1:DEPTH-1];
   logic             z_q, n_q, c_q;
   logic             z_d, n_d, c_d;
   logic             wr_en;

   // Write qualifier: discards writes to R0, to unused addresses, and while reset is held.
   always_comb begin
      wr_en = 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
         if (WE && RST_n && (WA == 3'(i))) wr_en = 1'b1;
      end
   end

   // Next-state for the register array: only the addressed entry takes WD.
   always_comb begin
      regs_d = regs_q;
      for (int i = 1; i < DEPTH; i++) begin
         if (wr_en && (WA == 3'(i))) regs_d[i] = WD;
      end
   end

   // Next-state for the flags; C is captured raw (1 after a subtract means no borrow).
   always_comb begin
      z_d = z_q;
      n_d = n_q;
      c_d = c_q;
      if (FWE) begin
         z_d = (Y_in == '0);
         n_d = Y_in[WIDTH-1];
         c_d = Cout_in;
      end
   end

   // Read ports: address 0 and unused addresses read zero; optional bypass of WD.
   always_comb begin
      RD1 = '0;
      RD2 = '0;
      for (int i = 1; i < DEPTH; i++) begin
         if (RA1 == 3'(i)) RD1 = regs_q[i];
         if (RA2 == 3'(i)) RD2 = regs_q[i];
      end
      if (BYPASS && wr_en && (RA1 == WA)) RD1 = WD;
      if (BYPASS && wr_en && (RA2 == WA)) RD2 = WD;
   end

   // State registers; asynchronous reset clears registers and flags immediately.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         for (int i = 1; i < DEPTH; i++) regs_q[i] <= '0;
         z_q <= 1'b0;
         n_q <= 1'b0;
         c_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         z_q    <= z_d;
         n_q    <= n_d;
         c_q    <= c_d;
      end
   end

   assign Z = z_q;
   assign N = n_q;
   assign C = c_q;

endmodule
